// File: rtl/seg7_pkg.sv
// Shared constants, scan-state type and hex-to-segment lookup for the 7-segment scanner.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg7_hex_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-high segments, bit 0 = a ... bit 6 = g.
    function automatic seg7_hex_t seg7_hex(input logic [3:0] nib);
        seg7_hex_t s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment decode; polarity is applied by the caller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = seg7_hex(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking guard and frame-aligned load commit.
// Outputs registered one cycle behind scan state; load_ready drops while a load is pending.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [15:0]           load_data,
    input  logic [NUM_DIGITS-1:0] load_en,
    input  logic [NUM_DIGITS-1:0] load_dp,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int              CNT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]      SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF     = SEG_ACTIVE_LOW;

    scan_state_t      state, state_nxt;
    logic [1:0]       digit, digit_nxt;
    logic [CNT_W-1:0] slot_cnt, cnt_nxt;
    logic             boundary;

    logic [15:0]           disp_data, pend_data;
    logic [NUM_DIGITS-1:0] disp_en, disp_dp, pend_en, pend_dp;
    logic                  pend_valid;
    logic                  accept;

    logic [3:0] nib;
    logic [6:0] hex_seg;
    logic       lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BLANK;
            digit    <= 2'd0;
            slot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            digit    <= digit_nxt;
            slot_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        cnt_nxt   = slot_cnt + 1'b1;
        boundary  = 1'b0;
        case (state)
            ST_BLANK: begin
                if (slot_cnt == BLANK_LAST) state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    digit_nxt = digit + 2'd1;
                    boundary  = (digit == 2'd3);
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    assign load_ready = ~pend_valid;
    assign accept     = load_valid & load_ready;

    // Commit only ever happens with pend_valid set, which holds load_ready low,
    // so a load landing on the boundary cycle can only fill an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            disp_en    <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary && pend_valid) begin
            disp_data  <= pend_data;
            disp_en    <= pend_en;
            disp_dp    <= pend_dp;
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_data  <= load_data;
            pend_en    <= load_en;
            pend_dp    <= load_dp;
            pend_valid <= 1'b1;
        end
    end

    assign nib = disp_data[{digit, 2'b00} +: 4];
    assign lit = (state == ST_SHOW) && disp_en[digit];

    seg7_hex_decode u_hex_decode (
        .nibble (nib),
        .segs   (hex_seg)
    );

    // XOR with the off pattern applies the configured segment polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= lit ? ~(4'b0001 << digit) : 4'b1111;
            seg         <= lit ? (hex_seg ^ SEG_OFF) : SEG_OFF;
            dp          <= (lit && disp_dp[digit]) ^ DP_OFF;
            frame_start <= boundary;
        end
    end

endmodule
